// File: rtl/pll_reset_seq_if.sv
// Phase/duty configuration handshake between a requester and the PLL
// reset sequencer. The requester holds cfg_req until it sees cfg_ack.
interface pll_reset_seq_if;
    logic       cfg_req;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_duty;
    logic       cfg_ack;

    modport master (
        output cfg_req,
        output cfg_psda,
        output cfg_duty,
        input  cfg_ack
    );

    modport slave (
        input  cfg_req,
        input  cfg_psda,
        input  cfg_duty,
        output cfg_ack
    );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL reset / lock sequencer: pulses the PLL reset, waits for a stable lock,
// releases the downstream reset and applies phase/duty updates while running.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_RST       | pll_reset_p asserted for RST_CYCLES cycles
// S_WAIT_LOCK | waiting for lock, LOCK_TIMEOUT cycles before a retry
// S_STABLE    | counting STABLE_CYCLES consecutive locked cycles
// S_RUN       | PLL ready, downstream reset released, accepting config
// S_CFG       | settling after a phase/duty update, lock ignored meanwhile
// S_FAIL      | retries exhausted, terminal until rst_n
module pll_reset_seq #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    output logic                  pll_reset_p,
    output logic [3:0]            pll_psda,
    output logic [3:0]            pll_dutyda,
    pll_reset_seq_if.slave        cfg,
    output logic                  pll_ready,
    output logic                  sys_rst_n,
    output logic                  pll_fail,
    output logic                  lock_lost,
    output logic [3:0]            retry_cnt
);

    // One shared counter serves every timed state; it must hold the largest
    // terminal value, including SETTLE_CYCLES itself (CFG compares against it).
    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B   = (STABLE_CYCLES > (SETTLE_CYCLES + 1)) ? STABLE_CYCLES
                                                                           : (SETTLE_CYCLES + 1);
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_DONE  = CNT_W'(SETTLE_CYCLES);
    localparam logic [3:0]       MAX_RETRY_V  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_CFG       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, lock_s_q;

    logic             lose_lock;
    logic             take_cfg;
    logic             retry_inc;

    logic             pll_reset_p_q, pll_reset_p_d;
    logic             pll_ready_q, pll_ready_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             pll_fail_q, pll_fail_d;
    logic             cfg_ack_q, cfg_ack_d;
    logic             lock_lost_q, lock_lost_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic [3:0]       pll_psda_q, pll_psda_d;
    logic [3:0]       pll_dutyda_q, pll_dutyda_d;

    // Bring the asynchronous PLL lock into the clkin domain.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // State and shared counter register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; lock loss takes priority over a config request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        lose_lock = 1'b0;
        take_cfg  = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_cnt_q < MAX_RETRY_V) begin
                        state_d   = S_RST;
                        retry_inc = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d   = S_RST;
                    lose_lock = 1'b1;
                end else if (cfg.cfg_req) begin
                    state_d  = S_CFG;
                    take_cfg = 1'b1;
                end
            end
            S_CFG: begin
                // Lock may glitch while the PLL re-phases; only the sample
                // taken after the settle window counts.
                if (cnt_q == SETTLE_DONE) begin
                    cnt_d = '0;
                    if (lock_s_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d   = S_RST;
                        lose_lock = 1'b1;
                    end
                end
            end
            S_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values, decoded from the upcoming state so that every
    // output is a flop that changes on the same edge as the state.
    always_comb begin
        pll_reset_p_d = (state_d == S_RST) || (state_d == S_FAIL);
        pll_ready_d   = (state_d == S_RUN);
        sys_rst_n_d   = (state_d == S_RUN) || (state_d == S_CFG);
        pll_fail_d    = (state_d == S_FAIL);
        cfg_ack_d     = take_cfg;
        lock_lost_d   = lock_lost_q | lose_lock;
        retry_cnt_d   = retry_cnt_q;
        if (lose_lock) begin
            retry_cnt_d = 4'd0;
        end else if (retry_inc) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
        end
        pll_psda_d   = take_cfg ? cfg.cfg_psda : pll_psda_q;
        pll_dutyda_d = take_cfg ? cfg.cfg_duty : pll_dutyda_q;
    end

    // Output registers; phase/duty survive retries and only reset on rst_n.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            pll_reset_p_q <= 1'b1;
            pll_ready_q   <= 1'b0;
            sys_rst_n_q   <= 1'b0;
            pll_fail_q    <= 1'b0;
            cfg_ack_q     <= 1'b0;
            lock_lost_q   <= 1'b0;
            retry_cnt_q   <= 4'd0;
            pll_psda_q    <= 4'b0000;
            pll_dutyda_q  <= 4'b1000;
        end else begin
            pll_reset_p_q <= pll_reset_p_d;
            pll_ready_q   <= pll_ready_d;
            sys_rst_n_q   <= sys_rst_n_d;
            pll_fail_q    <= pll_fail_d;
            cfg_ack_q     <= cfg_ack_d;
            lock_lost_q   <= lock_lost_d;
            retry_cnt_q   <= retry_cnt_d;
            pll_psda_q    <= pll_psda_d;
            pll_dutyda_q  <= pll_dutyda_d;
        end
    end

    assign pll_reset_p = pll_reset_p_q;
    assign pll_ready   = pll_ready_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign pll_fail    = pll_fail_q;
    assign cfg.cfg_ack = cfg_ack_q;
    assign lock_lost   = lock_lost_q;
    assign retry_cnt   = retry_cnt_q;
    assign pll_psda    = pll_psda_q;
    assign pll_dutyda  = pll_dutyda_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with short timing parameters.
// Edge k means the k-th rising clkin edge after rst_n is released;
// outputs are sampled 1 time unit after that edge.
module tb_pll_reset_seq;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset_p;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       pll_ready;
    logic       sys_rst_n;
    logic       pll_fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    int errors = 0;
    int checks = 0;

    pll_reset_seq_if cfg_if ();

    pll_reset_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (2),
        .SETTLE_CYCLES(5)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .pll_reset_p(pll_reset_p),
        .pll_psda   (pll_psda),
        .pll_dutyda (pll_dutyda),
        .cfg        (cfg_if),
        .pll_ready  (pll_ready),
        .sys_rst_n  (sys_rst_n),
        .pll_fail   (pll_fail),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    always #5 clkin = ~clkin;

    // {reset_p, sys_rst_n, ready, fail, ack, lost, retry, psda, duty}
    wire [17:0] out_vec = {pll_reset_p, sys_rst_n, pll_ready, pll_fail, cfg_if.cfg_ack,
                           lock_lost, retry_cnt, pll_psda, pll_dutyda};
    localparam logic [17:0] RST_VEC = {6'b100000, 4'd0, 4'd0, 4'd8};

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        cfg_if.cfg_req = 1'b0;
        cfg_if.cfg_psda = 4'd0;
        cfg_if.cfg_duty = 4'd0;
        repeat (2) @(posedge clkin);
        @(negedge clkin);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cfg_if.cfg_req = 1'b0;
        cfg_if.cfg_psda = 4'd0;
        cfg_if.cfg_duty = 4'd0;
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if (out_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_async_values: got %h expected %h", out_vec, RST_VEC);
        end
        step(2);
        checks++;
        if (out_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_held_values: got %h expected %h", out_vec, RST_VEC);
        end
    endtask

    task automatic test_normal_lock();
        int bad;
        release_reset();
        bad = 0;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            if (pll_reset_p !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL normal_reset_p_high: low at %0d of edges 1..3, expected high", bad);
        end
        step(1);
        checks++;
        if (pll_reset_p !== 1'b0) begin
            errors++;
            $display("FAIL normal_reset_p_fall: got %b expected 0 at edge 4", pll_reset_p);
        end
        step(3);
        pll_lock = 1'b1;
        step(10);
        checks++;
        if (pll_ready !== 1'b0) begin
            errors++;
            $display("FAIL normal_ready_early: got %b expected 0 at edge 17", pll_ready);
        end
        step(1);
        checks++;
        if ({pll_ready, sys_rst_n, retry_cnt} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL normal_run: ready=%b sys_rst_n=%b retry=%0d expected 1 1 0",
                     pll_ready, sys_rst_n, retry_cnt);
        end
    endtask

    task automatic test_config_run();
        int low;
        int acks;
        int srn_bad;
        cfg_if.cfg_psda = 4'b0101;
        cfg_if.cfg_duty = 4'b0110;
        cfg_if.cfg_req = 1'b1;
        step(1);
        checks++;
        if ({cfg_if.cfg_ack, pll_psda, pll_dutyda, pll_ready, sys_rst_n} !==
            {1'b1, 4'b0101, 4'b0110, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cfg_accept: ack=%b psda=%b duty=%b ready=%b srn=%b expected 1 0101 0110 0 1",
                     cfg_if.cfg_ack, pll_psda, pll_dutyda, pll_ready, sys_rst_n);
        end
        cfg_if.cfg_req = 1'b0;
        low = 1;
        acks = 1;
        srn_bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (cfg_if.cfg_ack === 1'b1) acks++;
            if (sys_rst_n !== 1'b1) srn_bad++;
            if (pll_ready === 1'b1) break;
            low++;
        end
        checks++;
        if (pll_ready !== 1'b1 || low < 5 || low > 6) begin
            errors++;
            $display("FAIL cfg_ready_low: ready=%b low for %0d cycles, expected 5..6 then ready",
                     pll_ready, low);
        end
        checks++;
        if (acks != 1 || srn_bad != 0) begin
            errors++;
            $display("FAIL cfg_single_ack: acks=%0d sys_rst_n low %0d cycles, expected 1 and 0",
                     acks, srn_bad);
        end
    endtask

    task automatic test_cfg_pending();
        int acks;
        release_reset();
        cfg_if.cfg_psda = 4'b0011;
        cfg_if.cfg_duty = 4'b1001;
        cfg_if.cfg_req = 1'b1;
        acks = 0;
        for (int k = 1; k <= 18; k++) begin
            step(1);
            if (k == 7) pll_lock = 1'b1;
            if (cfg_if.cfg_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || pll_psda !== 4'd0 || pll_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_pending_no_ack: acks=%0d psda=%b ready=%b expected 0 0000 1",
                     acks, pll_psda, pll_ready);
        end
        step(1);
        checks++;
        if ({cfg_if.cfg_ack, pll_psda, pll_dutyda} !== {1'b1, 4'b0011, 4'b1001}) begin
            errors++;
            $display("FAIL cfg_pending_first_run: ack=%b psda=%b duty=%b expected 1 0011 1001",
                     cfg_if.cfg_ack, pll_psda, pll_dutyda);
        end
        cfg_if.cfg_req = 1'b0;
        step(1);
        checks++;
        if (cfg_if.cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ack_width: got %b expected 0 one cycle after ack", cfg_if.cfg_ack);
        end
        for (int k = 0; k < 20 && pll_ready !== 1'b1; k++) step(1);
        checks++;
        if (pll_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_pending_return: ready=%b expected 1 after settle", pll_ready);
        end
    endtask

    task automatic test_lock_loss();
        int hi;
        pll_lock = 1'b0;
        step(2);
        checks++;
        if (sys_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL loss_sync_delay: sys_rst_n=%b expected 1 two edges after drop", sys_rst_n);
        end
        step(1);
        checks++;
        if ({sys_rst_n, pll_ready, lock_lost, pll_reset_p, retry_cnt, pll_psda, pll_dutyda} !==
            {1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'b0011, 4'b1001}) begin
            errors++;
            $display("FAIL loss_react: srn=%b rdy=%b lost=%b rstp=%b retry=%0d psda=%b duty=%b expected 0 0 1 1 0 0011 1001",
                     sys_rst_n, pll_ready, lock_lost, pll_reset_p, retry_cnt, pll_psda, pll_dutyda);
        end
        pll_lock = 1'b1;
        hi = 1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (pll_reset_p !== 1'b1) break;
            hi++;
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL loss_reset_pulse: high %0d cycles expected 4", hi);
        end
        for (int k = 0; k < 30 && pll_ready !== 1'b1; k++) step(1);
        checks++;
        if (pll_ready !== 1'b1 || lock_lost !== 1'b1 || sys_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL loss_relock: ready=%b lost=%b srn=%b expected 1 1 1",
                     pll_ready, lock_lost, sys_rst_n);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clkin);
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if (out_vec !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset_mid_run: got %h expected %h", out_vec, RST_VEC);
        end
    endtask

    task automatic test_glitch();
        release_reset();
        for (int k = 1; k <= 26; k++) begin
            step(1);
            if (k == 7) pll_lock = 1'b1;
            if (k == 14) pll_lock = 1'b0;
            if (k == 15) pll_lock = 1'b1;
            if (k == 18) begin
                checks++;
                if (pll_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_no_early_ready: got %b expected 0 at edge 18", pll_ready);
                end
            end
            if (k == 25) begin
                checks++;
                if (pll_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_ready_25: got %b expected 0", pll_ready);
                end
            end
        end
        checks++;
        if ({pll_ready, retry_cnt, lock_lost} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL glitch_ready_26: ready=%b retry=%0d lost=%b expected 1 0 0",
                     pll_ready, retry_cnt, lock_lost);
        end
    endtask

    task automatic test_never_lock();
        int   bad;
        int   first_bad;
        logic exp_rp;
        release_reset();
        bad = 0;
        first_bad = 0;
        for (int k = 1; k <= 90; k++) begin
            step(1);
            exp_rp = (k < 4) || (k >= 24 && k < 28) || (k >= 48 && k < 52) || (k >= 72);
            if (pll_reset_p !== exp_rp) begin
                if (bad == 0) first_bad = k;
                bad++;
            end
            if (k == 30) begin
                checks++;
                if (retry_cnt !== 4'd1) begin
                    errors++;
                    $display("FAIL never_retry1: got %0d expected 1", retry_cnt);
                end
            end
            if (k == 50) begin
                checks++;
                if (retry_cnt !== 4'd2) begin
                    errors++;
                    $display("FAIL never_retry2: got %0d expected 2", retry_cnt);
                end
            end
            if (k == 71) begin
                checks++;
                if (pll_fail !== 1'b0) begin
                    errors++;
                    $display("FAIL never_fail_early: got %b expected 0 at edge 71", pll_fail);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL never_reset_p_wave: %0d wrong samples, first at edge %0d", bad, first_bad);
        end
        checks++;
        if ({pll_fail, pll_reset_p, sys_rst_n, pll_ready, retry_cnt} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL never_terminal: fail=%b rstp=%b srn=%b rdy=%b retry=%0d expected 1 1 0 0 2",
                     pll_fail, pll_reset_p, sys_rst_n, pll_ready, retry_cnt);
        end
    endtask

    initial begin
        cfg_if.cfg_req = 1'b0;
        cfg_if.cfg_psda = 4'd0;
        cfg_if.cfg_duty = 4'd0;
        test_reset();
        test_normal_lock();
        test_config_run();
        test_async_reset();
        test_cfg_pending();
        test_lock_loss();
        test_async_reset();
        test_glitch();
        test_never_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  RST_CYCLES 16 -- pll_reset_p pulse width in clkin cycles.
  LOCK_TIMEOUT 65535 -- maximum WAIT_LOCK cycles before a retry.
  STABLE_CYCLES 1024 -- consecutive locked cycles required before release.
  MAX_RETRY 3 -- timeout retries before failure, at most 15.
  SETTLE_CYCLES 64 -- wait after a phase/duty update.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clkin in 1 -- free-running PLL reference clock, the only clock.
  rst_n in 1 -- asynchronous, active-low reset.
  pll_lock in 1 -- PLL LOCK, asynchronous to clkin.
  pll_reset_p out 1 -- drives PLL RESET_P.
  pll_psda out 4 -- drives PLL PSDA.
  pll_dutyda out 4 -- drives PLL DUTYDA.
  cfg_req in 1 -- phase/duty update request, level-held.
  cfg_psda in 4 -- requested phase setting.
  cfg_duty in 4 -- requested duty setting.
  cfg_ack out 1 -- one-cycle acceptance pulse.
  pll_ready out 1 -- PLL locked and stable.
  sys_rst_n out 1 -- downstream reset, active-low.
  pll_fail out 1 -- terminal failure flag.
  lock_lost out 1 -- sticky flag: lock dropped while in RUN.
  retry_cnt out 4 -- timeout retries used.

Function
REQ-003 pll_lock SHALL pass through a 2-flop synchronizer to lock_s; all decisions SHALL use lock_s only.
REQ-004 The FSM SHALL have exactly six states: RST, WAIT_LOCK, STABLE, RUN, CFG, FAIL.
REQ-005 All outputs SHALL be registered.
REQ-006 In RST, pll_reset_p SHALL be 1 for exactly RST_CYCLES cycles; the FSM SHALL then enter WAIT_LOCK with the timeout counter at 0.
REQ-007 In WAIT_LOCK with lock_s=1, the FSM SHALL enter STABLE with the stable counter at 0.
REQ-008 In WAIT_LOCK after LOCK_TIMEOUT cycles without lock: if retry_cnt<MAX_RETRY, retry_cnt SHALL increment and the FSM SHALL enter RST; otherwise it SHALL enter FAIL.
REQ-009 In STABLE, the stable counter SHALL increment each cycle lock_s=1; on reaching STABLE_CYCLES the FSM SHALL enter RUN.
REQ-010 Any lock_s=0 in STABLE SHALL return the FSM to WAIT_LOCK with the timeout counter cleared; retry_cnt SHALL be unchanged.
REQ-011 In RUN, pll_ready SHALL be 1 and sys_rst_n SHALL be 1; pll_reset_p SHALL be 0 in every state except RST and FAIL.
REQ-012 On lock_s=0 in RUN, the FSM SHALL enter RST, set lock_lost=1, and clear retry_cnt. pll_ready and sys_rst_n SHALL go 0 on the next clock edge.
REQ-013 In RUN with cfg_req=1 and lock_s=1, the block SHALL load cfg_psda/cfg_duty into pll_psda/pll_dutyda and pulse cfg_ack for exactly one cycle, coincident with the output update. The FSM SHALL then enter CFG.
REQ-014 If lock loss and cfg_req coincide in RUN, lock loss SHALL win and no ack SHALL be issued.
REQ-015 cfg_req outside RUN SHALL stay pending with no ack; it SHALL be serviced in the first RUN cycle. The requester SHALL drop cfg_req in the cycle after cfg_ack; a new request SHALL be taken only after returning to RUN.
REQ-016 In CFG, pll_ready SHALL be 0 and sys_rst_n SHALL stay 1. lock_s SHALL be ignored for SETTLE_CYCLES cycles, then sampled once:
  - lock_s=1: enter RUN.
  - lock_s=0: apply the REQ-012 actions.
REQ-017 pll_psda/pll_dutyda SHALL change only per REQ-013 or on reset; they SHALL be retained through RST retries.
REQ-018 FAIL SHALL be terminal until rst_n: pll_fail=1, pll_reset_p=1, sys_rst_n=0, pll_ready=0.

Reset
REQ-019 rst_n=0 SHALL take effect immediately (asynchronously), including mid-operation, and SHALL set:
  - state RST with its counter at 0;
  - pll_reset_p=1, sys_rst_n=0, pll_ready=0, pll_fail=0, cfg_ack=0, lock_lost=0;
  - retry_cnt=0, pll_psda=0000, pll_dutyda=1000;
  - synchronizer flops 0.
REQ-020 After rst_n deasserts, the RST state SHALL count the full RST_CYCLES.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2, SETTLE_CYCLES=5)
REQ-021 Normal lock: pll_lock rises 3 cycles after pll_reset_p falls and stays high -> pll_reset_p high exactly 4 cycles; pll_ready and sys_rst_n rise 10-12 cycles after the pll_lock rise; retry_cnt=0.
REQ-022 Never lock: pll_lock held 0 -> three 4-cycle pll_reset_p pulses, each 20 cycles apart. Then pll_fail=1, retry_cnt=2, pll_reset_p held 1, sys_rst_n=0 indefinitely.
REQ-023 Glitch in STABLE: 1-cycle pll_lock low after 5 locked cycles -> stable count restarts; pll_ready is delayed accordingly; retry_cnt is unchanged.
REQ-024 Lock loss in RUN: pll_lock falls -> sys_rst_n=0 within 3 cycles, lock_lost=1, a new 4-cycle pll_reset_p pulse; relock -> pll_ready returns.
REQ-025 Config: cfg_req with psda=0101, duty=0110 in RUN -> one cfg_ack pulse; outputs become 0101/0110; pll_ready low 5-6 cycles; sys_rst_n stays 1. cfg_req raised during WAIT_LOCK -> no ack until the first RUN cycle.
REQ-026 Async reset: rst_n pulsed low mid-RUN, without a clkin edge -> all outputs at REQ-019 values immediately.
